// File: rtl/md5_pkg.sv
// Shared constants and helpers for the MD5 round-2 (G) step inversion.
// Holds the round-2 K table, the shift table, the FSM state enum and the G function.
package md5_pkg;

    localparam logic [31:0] K_G [16] = '{
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a
    };

    localparam logic [4:0] S_G [4] = '{5'd5, 5'd9, 5'd14, 5'd20};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [31:0] md5_g(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
        return (x & z) | (y & ~z);
    endfunction

    // Message word index for round-2 step j: (1 + 5j) mod 16, 4-bit wrap does the mod.
    function automatic logic [3:0] g_index(input logic [3:0] step);
        return 4'd1 + step * 4'd5;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
        return (v << s) | (v >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] s);
        return (v >> s) | (v << (6'd32 - {1'b0, s}));
    endfunction

endpackage

// File: rtl/md5_g_inv_step.sv
// Combinational inverse of one MD5 round-2 step: given the state after the
// step plus its M word, K and shift, recovers the state before it.
module md5_g_inv_step
    import md5_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    input  logic [31:0] i_m,
    input  logic [31:0] i_k,
    input  logic [4:0]  i_s,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d
);

    logic [31:0] w_diff;

    assign w_diff = i_b - i_c;
    // The forward step rotated (a,b,c,d) -> (d,new_b,b,c); undo the rotation first.
    assign o_b = i_c;
    assign o_c = i_d;
    assign o_d = i_a;
    assign o_a = rotr32(w_diff, i_s) - md5_g(i_c, i_d, i_a) - i_m - i_k;

endmodule

// File: rtl/md5_g_unround.sv
// Iteratively undoes up to 16 MD5 round-2 steps, one per RUN cycle.
// Optional forward self-check is compiled in with MD5_UNROUND_SELFCHECK_EN.
module md5_g_unround
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  a_in,
    input  logic [31:0]  b_in,
    input  logic [31:0]  c_in,
    input  logic [31:0]  d_in,
    input  logic [511:0] msg,
    input  logic [3:0]   last_step,
    input  logic [4:0]   n_steps,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic         err,
    output logic         chk_err
);

    state_e       r_state;
    logic [31:0]  r_a, r_b, r_c, r_d;
    logic [511:0] r_msg;
    logic [3:0]   r_step;
    logic [4:0]   r_cnt;
    logic         r_err;

    logic [31:0]  w_a, w_b, w_c, w_d, w_m, w_k;
    logic [4:0]   w_s, w_n_max, w_cnt_in;
    logic [3:0]   w_g;

    assign w_g = g_index(r_step);
    assign w_m = r_msg[{w_g, 5'd0} +: 32];
    assign w_k = K_G[r_step];
    assign w_s = S_G[r_step[1:0]];

    // Never undo more steps than have been done, so step cannot go below 0.
    assign w_n_max  = {1'b0, last_step} + 5'd1;
    assign w_cnt_in = (n_steps > w_n_max) ? w_n_max : n_steps;

    md5_g_inv_step u_inv (
        .i_a (r_a),
        .i_b (r_b),
        .i_c (r_c),
        .i_d (r_d),
        .i_m (w_m),
        .i_k (w_k),
        .i_s (w_s),
        .o_a (w_a),
        .o_b (w_b),
        .o_c (w_c),
        .o_d (w_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_msg   <= '0;
            r_step  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_c     <= c_in;
                        r_d     <= d_in;
                        r_msg   <= msg;
                        r_step  <= last_step;
                        r_cnt   <= w_cnt_in;
                        r_err   <= (n_steps > w_n_max);
                        r_state <= (w_cnt_in == 5'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a   <= w_a;
                    r_b   <= w_b;
                    r_c   <= w_c;
                    r_d   <= w_d;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_step != 4'd0) begin
                        r_step <= r_step - 4'd1;
                    end
                    if (r_cnt == 5'd1) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign a_out     = r_a;
    assign b_out     = r_b;
    assign c_out     = r_c;
    assign d_out     = r_d;
    assign err       = r_err;

`ifdef MD5_UNROUND_SELFCHECK_EN
    logic [31:0] w_fwd_sum, w_fwd_b;
    logic        r_chk;

    // Redo the step forward from the recovered state; it must land on the current registers.
    assign w_fwd_sum = w_a + md5_g(w_b, w_c, w_d) + w_m + w_k;
    assign w_fwd_b   = w_b + rotl32(w_fwd_sum, w_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk <= 1'b0;
        end else if (r_state == ST_RUN &&
                     {w_d, w_fwd_b, w_b, w_c} != {r_a, r_b, r_c, r_d}) begin
            r_chk <= 1'b1;
        end
    end

    assign chk_err = r_chk;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_md5_g_unround.sv
// Bench for md5_g_unround: vectors built from a forward MD5 round-2 model,
// plus backpressure and mid-run reset sequences.
module tb_md5_g_unround;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  a_in, b_in, c_in, d_in;
    logic [511:0] msg;
    logic [3:0]   last_step;
    logic [4:0]   n_steps;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  a_out, b_out, c_out, d_out;
    logic         err;
    logic         chk_err;

    int n_checks;
    int n_fail;

    md5_g_unround dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .msg       (msg),
        .last_step (last_step),
        .n_steps   (n_steps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out),
        .d_out     (d_out),
        .err       (err),
        .chk_err   (chk_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // forward reference model of MD5 step i (16..31); state packed {a,b,c,d}
    logic [31:0] k_tab [16];
    int          s_tab [4];

    function automatic logic [127:0] fwd_step(input logic [127:0] st, input logic [511:0] m,
                                              input int i);
        logic [31:0] a, b, c, d, t, r;
        int j, s, g;
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        j = i - 16;
        s = s_tab[j % 4];
        g = (1 + 5 * j) % 16;
        t = a + ((b & d) | (c & ~d)) + m[32 * g +: 32] + k_tab[j];
        r = (t << s) | (t >> (32 - s));
        return {d, b + r, b, c};
    endfunction

    function automatic logic [127:0] fwd_range(input logic [127:0] st, input logic [511:0] m,
                                               input int first_i, input int last_i);
        logic [127:0] x;
        x = st;
        for (int i = first_i; i <= last_i; i++) x = fwd_step(x, m, i);
        return x;
    endfunction

    function automatic logic [511:0] rand_msg();
        logic [511:0] m;
        for (int k = 0; k < 16; k++) m[32 * k +: 32] = $urandom;
        return m;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // scoreboard
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic run_req(input logic [127:0] st, input logic [511:0] m, input logic [3:0] ls,
                           input logic [4:0] ns, output logic [127:0] got, output logic got_err,
                           output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_req", in_ready, 1'b1);
        {a_in, b_in, c_in, d_in} = st;
        msg       = m;
        last_step = ls;
        n_steps   = ns;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got     = {a_out, b_out, c_out, d_out};
        got_err = err;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] st_in;
        logic [511:0] m;
        logic [3:0]   ls;
        logic [4:0]   ns;
        logic [127:0] exp_st;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [127:0] got, orig, held;
        logic         got_err;
        int           lat, L, N, neff;
        logic [511:0] m;

        k_tab = '{32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
                  32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
                  32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
                  32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a};
        s_tab = '{5, 9, 14, 20};
        n_checks = 0;
        n_fail   = 0;

        // vector table
        vecs[0] = '{{32'd1, 32'd2, 32'd3, 32'd4}, '0, 4'd7, 5'd0,
                    {32'd1, 32'd2, 32'd3, 32'd4}, 1'b0, 0};
        vecs[1] = '{{32'd0, 32'hC3C4AC5E, 32'd0, 32'd0}, '0, 4'd0, 5'd1,
                    128'd0, 1'b0, 1};
        orig = rand_state();
        m    = rand_msg();
        vecs[2] = '{fwd_range(orig, m, 16, 31), m, 4'd15, 5'd16, orig, 1'b0, 16};
        orig = rand_state();
        m    = rand_msg();
        vecs[3] = '{fwd_range(orig, m, 16, 18), m, 4'd2, 5'd5, orig, 1'b1, 3};
        for (int v = 4; v < 10; v++) begin
            L    = $urandom_range(0, 15);
            N    = $urandom_range(0, 16);
            neff = (N > L + 1) ? L + 1 : N;
            orig = rand_state();
            m    = rand_msg();
            vecs[v] = '{fwd_range(orig, m, 16 + L - neff + 1, 16 + L), m, 4'(L), 5'(N),
                        orig, (N > L + 1), neff};
        end

        // reset
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; msg = '0; last_step = '0; n_steps = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {a_out, b_out, c_out, d_out, err, chk_err}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_ready_valid", {in_ready, out_valid}, 2'b10);

        // table-driven vectors
        for (int v = 0; v < 10; v++) begin
            run_req(vecs[v].st_in, vecs[v].m, vecs[v].ls, vecs[v].ns, got, got_err, lat);
            check($sformatf("vec%0d_state", v), got, vecs[v].exp_st);
            check($sformatf("vec%0d_err", v), got_err, vecs[v].exp_err);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            release_out();
        end
        check("chk_err_clean", chk_err, 1'b0);

        // backpressure: result held, in_ready low, stray in_valid ignored
        orig = rand_state();
        m    = rand_msg();
        run_req(fwd_range(orig, m, 20, 22), m, 4'd6, 5'd3, got, got_err, lat);
        check("bp_state", got, orig);
        held = got;
        for (int c = 0; c < 10; c++) begin
            in_valid  = c[0];
            {a_in, b_in, c_in, d_in} = rand_state();
            last_step = 4'd0;
            n_steps   = 5'd0;
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", c),
                  {a_out, b_out, c_out, d_out, err, out_valid, in_ready},
                  {held, 1'b0, 1'b1, 1'b0});
        end
        in_valid = 1'b1;
        release_out();
        check("release_same_cycle_not_taken", {in_ready, out_valid}, 2'b10);
        in_valid = 1'b0;

        // reset in the middle of a long run
        orig = rand_state();
        m    = rand_msg();
        {a_in, b_in, c_in, d_in} = fwd_range(orig, m, 16, 31);
        msg = m; last_step = 4'd15; n_steps = 5'd16; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_run_busy", {in_ready, out_valid}, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        check("mid_run_reset", {a_out, b_out, c_out, d_out, err, in_ready, out_valid},
              {128'd0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rst = 1'b0;

        // post-reset request still works
        run_req({32'd9, 32'd8, 32'd7, 32'd6}, '0, 4'd3, 5'd0, got, got_err, lat);
        check("post_reset_passthrough", got, {32'd9, 32'd8, 32'd7, 32'd6});
        release_out();

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
